mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares a single main-memory port between two cache controllers, e.g. an instruction cache and a data cache. It sits between the controllers' memory-request ports and main memory. It presents the same pulse-valid / level-ready line-transfer handshake on both sides, so each controller behaves as if it owned memory. Requests are latched, granted round-robin, and served one at a time.

## Interface
- ADDR_W, 32, request address width
- LINE_W, 128, cache-line data width
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT (used only with MEM_ARB_TIMEOUT_EN)

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- pN_addr  in  ADDR_W  port N (N=0,1) line address
- pN_wdata  in  LINE_W  port N write line
- pN_rw  in  1  port N direction: 1=write, 0=read
- pN_valid  in  1  port N one-cycle request pulse
- pN_rdata  out  LINE_W  port N returned read line, registered
- pN_ready  out  1  port N: 1 = no outstanding request / transfer done
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  LINE_W  memory write line, registered
- mem_rw  out  1  memory direction
- mem_valid  out  1  one-cycle request pulse to memory
- mem_rdata  in  LINE_W  memory read line, valid while mem_ready=1 after a read
- mem_ready  in  1  memory idle / transfer done (level)
- grant_id  out  1  port currently owning memory (last granted when idle)
- busy  out  1  1 while in WAIT
- timeout_err  out  1  sticky watchdog error

## Operation
- Reset values:
  - pN_ready=1, pN_rdata=0
  - mem_addr=0, mem_wdata=0, mem_rw=0, mem_valid=0
  - grant_id=0, busy=0, timeout_err=0
  - state=IDLE, priority pointer=0, pending flags and capture registers cleared
- Capture:
  - pN_valid sampled high: the edge latches addr/wdata/rw into port N's capture registers, sets pending_N and clears pN_ready.
  - pN_valid while pending_N=1 is a protocol violation; it is ignored and the first request is preserved.
- States:
  - IDLE:
    - If any pending flag is set, grant one port.
    - Only one pending: grant it.
    - Both pending: grant the port named by the priority pointer.
    - On the grant edge: mem_addr/mem_wdata/mem_rw <= captured values, mem_valid <= 1, grant_id <= N, clear pending_N, priority <= ~N, state <= WAIT.
  - WAIT:
    - mem_valid <= 0 on the first WAIT edge.
    - Completion is the condition mem_valid=0 && mem_ready=1.
    - On completion, for a read: pN_rdata <= mem_rdata.
    - On completion, for a write: pN_rdata is unchanged.
    - On completion: pN_ready <= 1, state <= IDLE.
- A port's captured request is never lost while the other port is being served.
- Memory is never sent a second mem_valid before completion.
- Reset asserted mid-transfer: all state returns to reset values immediately and pending requests are discarded. Memory-side recovery is the system's responsibility.

## Timing
- Valid-to-issue:
  - Request sampled at edge C, arbiter idle: mem_valid=1 after edge C+1, mem_valid=0 after C+2.
- Completion:
  - mem_ready sampled high at edge D in WAIT (mem_valid low): pN_ready=1 and pN_rdata updated after D.
  - The next grant issues at D+1 at the earliest.
- Ready drop:
  - pN_ready falls after the capture edge, before the requester's first post-pulse ready check.
- Contested:
  - Both valid at the same edge C, pointer=0: port 0 issues at C+1.
  - Port 1 issues at the edge after port 0's completion.
- Simultaneous new capture and completion on different ports in the same cycle: both take effect.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without completion forces completion for the granted port: pN_rdata <= 0, pN_ready <= 1, timeout_err <= 1 (sticky until reset), state <= IDLE.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter; WAIT lasts until completion.
  - timeout_err is tied to 0.

## Test plan
- Single read, port 0, addr 0x0000_1230: mem_valid pulse 1 cycle with mem_addr=0x0000_1230, mem_rw=0. Memory returns 0xAAAA…AAAA after 3 cycles -> p0_rdata=0xAAAA…AAAA, p0_ready=1, p1 untouched.
- Simultaneous reads, ports 0 and 1, pointer=0 -> port 0 served first, then port 1. A second simultaneous pair is served port 1 first (round-robin).
- Port 1 write, wdata=0x1111…1111, addr 0x8000_0040 -> mem_rw=1, mem_wdata matches. p1_rdata keeps its prior value; p1_ready returns to 1.
- Port 0 request arriving while port 1 is in WAIT -> p0_ready=0 immediately. Port 0 issues exactly one cycle after port 1 completes.
- Reset asserted during WAIT -> all outputs at reset values on the next sample; no spurious mem_valid after release.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready held 0 -> after 8 WAIT cycles the port gets ready=1, rdata=0, and timeout_err=1 until reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports and the shared memory port
// of mem_arbiter.
//   p0_*/p1_*  : requester side (addr, wdata, rw, valid in; rdata, ready out)
//   mem_*      : memory side (addr, wdata, rw, valid out; rdata, ready in)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (cache controllers plus main memory)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic [ADDR_W-1:0] p0_addr,  p1_addr;
  logic [LINE_W-1:0] p0_wdata, p1_wdata;
  logic              p0_rw,    p1_rw;
  logic              p0_valid, p1_valid;
  logic [LINE_W-1:0] p0_rdata, p1_rdata;
  logic              p0_ready, p1_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_rw;
  logic              mem_valid;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  p0_addr, p0_wdata, p0_rw, p0_valid,
    input  p1_addr, p1_wdata, p1_rw, p1_valid,
    output p0_rdata, p0_ready, p1_rdata, p1_ready,
    output mem_addr, mem_wdata, mem_rw, mem_valid,
    input  mem_rdata, mem_ready
  );

  modport master (
    output p0_addr, p0_wdata, p0_rw, p0_valid,
    output p1_addr, p1_wdata, p1_rw, p1_valid,
    input  p0_rdata, p0_ready, p1_rdata, p1_ready,
    input  mem_addr, mem_wdata, mem_rw, mem_valid,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between two cache controllers.
// Each requester pulses valid for one cycle; the request is latched, granted
// round-robin and issued to memory as a one-cycle mem_valid pulse. The port's
// ready returns high when memory finishes (mem_valid low, mem_ready high).
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   bus (slave)      : p0_*/p1_* requester ports and mem_* memory port
//   grant_id         : port owning memory (last granted when idle)
//   busy             : high while a transfer is outstanding
//   timeout_err      : sticky watchdog error
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a watchdog that forces
// completion (rdata=0) after TIMEOUT_CYCLES cycles in WAIT.

// Per-port capture slot: holds one request until granted and owns the port's
// ready/rdata outputs.
module mem_arb_port #(
  parameter type req_t  = logic,
  parameter int  LINE_W = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              vld,
  input  req_t              req,
  input  logic              grant,
  input  logic              done,
  input  logic              load,
  input  logic [LINE_W-1:0] rdata_in,
  output logic              pending,
  output req_t              cap,
  output logic              ready,
  output logic [LINE_W-1:0] rdata
);
  logic take;
  // A pulse while a request is still queued is dropped; the first one wins.
  assign take = vld && !pending;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      cap     <= '0;
      ready   <= 1'b1;
      rdata   <= '0;
    end else begin
      if (take) begin
        pending <= 1'b1;
        cap     <= req;
      end else if (grant) begin
        pending <= 1'b0;
      end
      if (take)      ready <= 1'b0;
      else if (done) ready <= 1'b1;
      if (done && load) rdata <= rdata_in;
    end
  end
endmodule

module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus,
  output logic          grant_id,
  output logic          busy,
  output logic          timeout_err
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              rw;
  } req_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                       state, state_nxt;
  logic                         prio;
  logic                         gnt_fire, gnt_sel;
  logic                         real_done, tmo_hit, tmo_force, finish;
  logic [NUM_PORTS-1:0]         req_vld, pending, ready, gnt_vec, done_vec;
  req_t [NUM_PORTS-1:0]         req_in, cap;
  logic [NUM_PORTS-1:0][LINE_W-1:0] rdata;
  logic                         load;
  logic [LINE_W-1:0]            rdata_in;

  assign req_vld   = {bus.p1_valid, bus.p0_valid};
  assign req_in[0] = {bus.p0_addr, bus.p0_wdata, bus.p0_rw};
  assign req_in[1] = {bus.p1_addr, bus.p1_wdata, bus.p1_rw};
  assign bus.p0_ready = ready[0];
  assign bus.p1_ready = ready[1];
  assign bus.p0_rdata = rdata[0];
  assign bus.p1_rdata = rdata[1];
  assign busy = (state == S_WAIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_fire  = 1'b0;
    gnt_sel   = prio;
    real_done = 1'b0;
    case (state)
      S_IDLE: if (|pending) begin
        gnt_fire  = 1'b1;
        // Pointer only matters when both wait; otherwise take the lone one.
        gnt_sel   = (&pending) ? prio : pending[1];
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // mem_valid is still high in the first WAIT cycle, so a stale
        // mem_ready from the previous transfer cannot complete this one.
        real_done = !bus.mem_valid && bus.mem_ready;
        if (real_done || tmo_hit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign tmo_force = tmo_hit && !real_done;
  assign finish    = real_done || tmo_hit;
  assign gnt_vec   = gnt_fire ? (NUM_PORTS'(1) << gnt_sel) : '0;
  assign done_vec  = finish ? (NUM_PORTS'(1) << grant_id) : '0;
  // mem_rw holds the granted direction for the whole transfer; the capture
  // slot may already have been refilled by a new request.
  assign load      = tmo_force || !bus.mem_rw;
  assign rdata_in  = tmo_force ? '0 : bus.mem_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_rw    <= 1'b0;
      bus.mem_valid <= 1'b0;
      grant_id      <= 1'b0;
      prio          <= 1'b0;
    end else begin
      bus.mem_valid <= gnt_fire;
      if (gnt_fire) begin
        bus.mem_addr  <= cap[gnt_sel].addr;
        bus.mem_wdata <= cap[gnt_sel].wdata;
        bus.mem_rw    <= cap[gnt_sel].rw;
        grant_id      <= gnt_sel;
        prio          <= ~gnt_sel;
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    mem_arb_port #(.req_t(req_t), .LINE_W(LINE_W)) u_port (
      .clock    (clock),
      .reset_n  (reset_n),
      .vld      (req_vld[i]),
      .req      (req_in[i]),
      .grant    (gnt_vec[i]),
      .done     (done_vec[i]),
      .load     (load),
      .rdata_in (rdata_in),
      .pending  (pending[i]),
      .cap      (cap[i]),
      .ready    (ready[i]),
      .rdata    (rdata[i])
    );
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt;

  // Counter holds the number of WAIT cycles already elapsed; the last one
  // fires when it reads TIMEOUT_CYCLES-1.
  assign tmo_hit = (state == S_WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (gnt_fire)              tmo_cnt <= '0;
      else if (state == S_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_force) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
